ddr2_local_port_arbiter: RTL

- Two-requester round-robin arbiter in front of the DDR2 high-performance controller's local interface, which has one port.
- Registers the granted command and presents it to the controller until accepted.
- Tracks outstanding reads and writes in owner FIFOs, so controller write-data requests and read-data beats reach the correct requester.
- Sits between the system interconnect masters and the controller wrapper.

---
 rtl/ddr2_local_port_arbiter_if.sv | 62 ++++++
 rtl/ddr2_local_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ddr2_local_port_arbiter_if.sv
// Bundle of the two requester ports and the single DDR2 controller local port.
// The arbiter sits on the slave modport. The master modport is the environment:
// the requesters plus the controller model.
interface ddr2_local_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24,
  parameter int SIZE_W = 2
);
  localparam int BE_W = DATA_W / 8;

  // Requester 0
  logic              m0_read, m0_write;
  logic [ADDR_W-1:0] m0_addr;
  logic [SIZE_W-1:0] m0_size;
  logic [DATA_W-1:0] m0_wdata;
  logic [BE_W-1:0]   m0_be;
  logic              m0_waitrequest, m0_wdata_req, m0_rdata_valid;
  logic [DATA_W-1:0] m0_rdata;

  // Requester 1
  logic              m1_read, m1_write;
  logic [ADDR_W-1:0] m1_addr;
  logic [SIZE_W-1:0] m1_size;
  logic [DATA_W-1:0] m1_wdata;
  logic [BE_W-1:0]   m1_be;
  logic              m1_waitrequest, m1_wdata_req, m1_rdata_valid;
  logic [DATA_W-1:0] m1_rdata;

  // Controller local port
  logic              local_init_done, local_ready, local_wdata_req, local_rdata_valid;
  logic [DATA_W-1:0] local_rdata;
  logic              local_read_req, local_write_req, local_burstbegin;
  logic [SIZE_W-1:0] local_size;
  logic [12:0]       local_row_addr;
  logic [1:0]        local_bank_addr;
  logic [8:0]        local_col_addr;
  logic [DATA_W-1:0] local_wdata;
  logic [BE_W-1:0]   local_be;
  logic              err_orphan;

  modport slave (
    input  m0_read, m0_write, m0_addr, m0_size, m0_wdata, m0_be,
    output m0_waitrequest, m0_wdata_req, m0_rdata, m0_rdata_valid,
    input  m1_read, m1_write, m1_addr, m1_size, m1_wdata, m1_be,
    output m1_waitrequest, m1_wdata_req, m1_rdata, m1_rdata_valid,
    input  local_init_done, local_ready, local_wdata_req, local_rdata, local_rdata_valid,
    output local_read_req, local_write_req, local_burstbegin, local_size,
    output local_row_addr, local_bank_addr, local_col_addr, local_wdata, local_be,
    output err_orphan
  );

  modport master (
    output m0_read, m0_write, m0_addr, m0_size, m0_wdata, m0_be,
    input  m0_waitrequest, m0_wdata_req, m0_rdata, m0_rdata_valid,
    output m1_read, m1_write, m1_addr, m1_size, m1_wdata, m1_be,
    input  m1_waitrequest, m1_wdata_req, m1_rdata, m1_rdata_valid,
    output local_init_done, local_ready, local_wdata_req, local_rdata, local_rdata_valid,
    input  local_read_req, local_write_req, local_burstbegin, local_size,
    input  local_row_addr, local_bank_addr, local_col_addr, local_wdata, local_be,
    input  err_orphan
  );
endinterface

// File: rtl/ddr2_local_port_arbiter.sv
// Two-requester round-robin arbiter in front of the DDR2 controller local port.
// A granted command is registered and held until local_ready. Owner FIFOs
// (index 0 = read, 1 = write) remember which requester each outstanding burst
// belongs to, so data requests and read beats get steered back correctly.
module ddr2_local_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 24,
  parameter int SIZE_W    = 2,
  parameter int OWN_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ddr2_local_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(OWN_DEPTH);
  localparam int CNT_W = $clog2(OWN_DEPTH + 1);
  localparam int RD    = 0;
  localparam int WR    = 1;

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic              port;
    logic [SIZE_W-1:0] size;
  } own_t;

  state_t            state, state_nxt;
  logic              grant_valid, grant_port;
  logic              last_grant, cmd_port, cmd_rd;
  logic              read_req_q, write_req_q, burstbegin_q;
  logic [SIZE_W-1:0] size_q, grant_size;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        want_rd, want_wr, elig;

  own_t              own_mem [2][OWN_DEPTH];
  own_t              head    [2];
  logic [PTR_W-1:0]  rd_ptr  [2];
  logic [PTR_W-1:0]  wr_ptr  [2];
  logic [CNT_W-1:0]  count   [2];
  logic [SIZE_W-1:0] beat    [2];
  logic [1:0]        room, nonempty, push, pop, fire;

  // A requester with both strobes high is treated as a read.
  assign want_rd = {bus.m1_read, bus.m0_read};
  assign want_wr = {bus.m1_write & ~bus.m1_read, bus.m0_write & ~bus.m0_read};

  // FIFO status, heads and data events. The reset gate keeps waitrequest high
  // while reset is asserted, whatever the requesters are driving.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      room[i]     = count[i] < CNT_W'(OWN_DEPTH);
      nonempty[i] = count[i] != '0;
      head[i]     = own_mem[i][rd_ptr[i]];
    end
    for (int n = 0; n < 2; n++) begin
      elig[n] = reset_n & bus.local_init_done & (state == IDLE) &
                ((want_rd[n] & room[RD]) | (want_wr[n] & room[WR]));
    end
    fire[RD] = bus.local_rdata_valid & nonempty[RD];
    fire[WR] = bus.local_wdata_req & nonempty[WR];
    push[RD] = (state == ISSUE) & bus.local_ready & cmd_rd;
    push[WR] = (state == ISSUE) & bus.local_ready & ~cmd_rd;
    for (int i = 0; i < 2; i++) begin
      pop[i] = fire[i] & (beat[i] == head[i].size - SIZE_W'(1));
    end
  end

  // Next state and round-robin grant.
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    case (state)
      IDLE: begin
        if (elig != 2'b00) begin
          grant_valid = 1'b1;
          grant_port  = (elig == 2'b11) ? ~last_grant : elig[1];
          state_nxt   = ISSUE;
        end
      end
      ISSUE:   if (bus.local_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst size of the winner; a zero size is promoted to one beat.
  always_comb begin
    grant_size = grant_port ? bus.m1_size : bus.m0_size;
    if (grant_size == '0) grant_size = SIZE_W'(1);
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Command register: latch the grant, hold strobes until accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant   <= 1'b1;
      cmd_port     <= 1'b0;
      cmd_rd       <= 1'b0;
      read_req_q   <= 1'b0;
      write_req_q  <= 1'b0;
      burstbegin_q <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
    end else begin
      burstbegin_q <= 1'b0;
      if (grant_valid) begin
        last_grant   <= grant_port;
        cmd_port     <= grant_port;
        cmd_rd       <= want_rd[grant_port];
        read_req_q   <= want_rd[grant_port];
        write_req_q  <= ~want_rd[grant_port];
        burstbegin_q <= 1'b1;
        size_q       <= grant_size;
        addr_q       <= grant_port ? bus.m1_addr : bus.m0_addr;
      end else if (state == ISSUE && bus.local_ready) begin
        read_req_q  <= 1'b0;
        write_req_q <= 1'b0;
      end
    end
  end

  // Owner FIFO pointers, occupancy and beat counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
        beat[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (pop[i])       beat[i] <= '0;
        else if (fire[i]) beat[i] <= beat[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Owner FIFO storage.
  // NOTE: storage is not reset; an entry is only ever read after it was written, so clearing the pointers is enough.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) own_mem[i][wr_ptr[i]] <= '{port: cmd_port, size: size_q};
    end
  end

  // Sticky flag for data events that arrive with no owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.err_orphan <= 1'b0;
    else if ((bus.local_wdata_req & ~nonempty[WR]) | (bus.local_rdata_valid & ~nonempty[RD]))
      bus.err_orphan <= 1'b1;
  end

  assign bus.m0_waitrequest   = ~(grant_valid & ~grant_port);
  assign bus.m1_waitrequest   = ~(grant_valid & grant_port);
  assign bus.local_read_req   = read_req_q;
  assign bus.local_write_req  = write_req_q;
  assign bus.local_burstbegin = burstbegin_q;
  assign bus.local_size       = size_q;
  assign bus.local_row_addr   = addr_q[23:11];
  assign bus.local_bank_addr  = addr_q[10:9];
  assign bus.local_col_addr   = addr_q[8:0];

  assign bus.m0_wdata_req   = fire[WR] & ~head[WR].port;
  assign bus.m1_wdata_req   = fire[WR] & head[WR].port;
  assign bus.local_wdata    = !nonempty[WR] ? '0 : (head[WR].port ? bus.m1_wdata : bus.m0_wdata);
  assign bus.local_be       = !nonempty[WR] ? '0 : (head[WR].port ? bus.m1_be : bus.m0_be);
  assign bus.m0_rdata       = bus.local_rdata;
  assign bus.m1_rdata       = bus.local_rdata;
  assign bus.m0_rdata_valid = fire[RD] & ~head[RD].port;
  assign bus.m1_rdata_valid = fire[RD] & head[RD].port;
endmodule
